mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- ADDR_W, 6, word-address width on the memory side.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum number of cycles to wait for mem_ack before aborting.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- cpu_rd, in, 1, pipeline load request.
- cpu_wr, in, 1, pipeline store request.
- cpu_addr, in, 32, byte address.
- cpu_wdata, in, DATA_W, store data.
- cpu_rdata, out, DATA_W, load result (registered).
- freeze, out, 1, pipeline stall request.
- err, out, 1, sticky error flag.
- mem_read, out, 1, read strobe to data memory.
- mem_write, out, 1, write strobe to data memory.
- mem_address, out, ADDR_W, word address to memory.
- mem_data, out, DATA_W, write data to memory.
- mem_result, in, DATA_W, read data from memory.
- mem_ack, in, 1, memory completion, sampled on the rising edge.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.

REQ-004 In IDLE, a request SHALL be classified as one of the following:
- Valid: exactly one of cpu_rd/cpu_wr is 1, cpu_addr[1:0]==0, and cpu_addr[31:ADDR_W+2]==0.
- Invalid: any other request with cpu_rd or cpu_wr set.

REQ-005 IDLE transitions SHALL be as follows:
- Valid read: go to READ.
- Valid write: go to WRITE.
- Invalid request: go to DONE, set err, load cpu_rdata with 0, and issue no memory strobe.
- No request: stay in IDLE.

REQ-006 On leaving IDLE, mem_address SHALL be registered as cpu_addr[ADDR_W+1:2] and mem_data as cpu_wdata; both SHALL hold stable until the next accepted request.

REQ-007 Strobe levels SHALL be as follows:
- mem_read=1 exactly while in READ.
- mem_write=1 exactly while in WRITE.
- Both 0 in IDLE and DONE.
- Both never 1 simultaneously.

REQ-008 In READ, mem_ack=1 SHALL cause the edge to capture mem_result into cpu_rdata and move to DONE.

REQ-009 In WRITE, mem_ack=1 SHALL cause a move to DONE with cpu_rdata unchanged.

REQ-010 A wait counter SHALL clear on entering READ/WRITE and increment each cycle without mem_ack.

REQ-011 If the counter reaches TIMEOUT-1 with no ack, the FSM SHALL go to DONE, set err, and load cpu_rdata with 0 (reads only).

REQ-012 DONE SHALL last exactly one cycle and then go unconditionally to IDLE.

REQ-013 freeze SHALL be combinational:
- freeze=1 in IDLE when any request (valid or invalid) is present.
- freeze=1 in READ and WRITE.
- freeze=0 in DONE and in IDLE with no request.

REQ-014 Access latency SHALL be measured from the request edge to the DONE cycle:
- Zero-wait memory (mem_ack=1 on the first READ/WRITE cycle): freeze high for exactly 2 cycles, then DONE.
- Each wait cycle: adds exactly 1 cycle.

REQ-015 Request inputs SHALL be ignored in READ, WRITE and DONE.
- A request still asserted in DONE is the completing instruction and SHALL NOT be re-issued.

REQ-016 A mem_ack asserted while in IDLE or DONE SHALL be ignored.

REQ-017 err SHALL remain 1 once set, until rst.

Reset
REQ-018 On rst=1, regardless of clk, the following outputs SHALL take these values:
- State: IDLE.
- mem_read=0, mem_write=0.
- mem_address=0, mem_data=0.
- cpu_rdata=0.
- err=0.
- Wait counter: 0.

REQ-019 Reset asserted mid-access SHALL drop both strobes immediately and abandon the access.
- A later mem_ack SHALL have no effect.

REQ-020 After rst deasserts, the first request SHALL be accepted on the first rising edge.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- Zero-wait read:
  - Stimulus: memory word 5 = 0x12345678; cpu_rd=1, cpu_addr=0x14; mem_ack=1 on the first READ cycle.
  - Response: mem_address=5; freeze high for 2 cycles; cpu_rdata=0x12345678 in DONE; err=0.
- Three-wait write:
  - Stimulus: cpu_wr=1, cpu_addr=0xFC, cpu_wdata=0xA5A5A5A5; mem_ack on the 4th WRITE cycle.
  - Response: mem_write high for 4 cycles; mem_address=63; freeze high for 5 cycles; word 63=0xA5A5A5A5.
- Invalid requests:
  - Stimulus: cpu_addr=0x13 with cpu_rd=1; then cpu_addr=0x100; then cpu_rd=cpu_wr=1.
  - Response: for each, no strobe, freeze 1 cycle, then DONE; cpu_rdata=0; err=1 and stays 1.
- Read timeout:
  - Stimulus: read with mem_ack tied 0.
  - Response: mem_read high exactly 15 cycles; then DONE with cpu_rdata=0; err=1.
- Reset mid-read:
  - Stimulus: assert rst on the 2nd READ cycle, between edges.
  - Response: mem_read=0 immediately; state IDLE; a mem_ack one cycle later changes nothing; err=0.
- Back-to-back accesses:
  - Stimulus: read word 1, then write word 2 with no gap.
  - Response: second request accepted in the IDLE cycle right after DONE; strobes never overlap.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store bridge between the pipeline and a word-addressed
// data memory: ack handshake, bounded wait with timeout, and a sticky error flag.
module mem_access_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              freeze,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req;
    logic              req_ok;

    // A request is serviceable only if it is a single direction, word aligned,
    // and lies inside the memory's word-address range.
    function automatic logic req_valid(input logic rd, input logic wr, input logic [31:0] addr);
        return (rd ^ wr) && (addr[1:0] == 2'b00) && ((addr >> (ADDR_W + 2)) == 32'd0);
    endfunction

    assign req    = cpu_rd | cpu_wr;
    assign req_ok = req_valid(cpu_rd, cpu_wr, cpu_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        freeze    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    freeze = 1'b1;
                    addr_d = cpu_addr[ADDR_W+1:2];
                    data_d = cpu_wdata;
                    cnt_d  = '0;
                    if (req_ok) begin
                        state_d = cpu_rd ? READ : WRITE;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            READ: begin
                freeze   = 1'b1;
                mem_read = 1'b1;
                if (mem_ack) begin
                    rdata_d = mem_result;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                freeze    = 1'b1;
                mem_write = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // DONE is the pipeline's release cycle; any request still present is the
            // instruction that just completed, so it is deliberately not looked at.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata   = rdata_q;
    assign err         = err_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic against a
// transaction-level model; a monitor scores each completed access at DONE.
module tb_mem_access_ctrl;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT   = 15;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_rd, cpu_wr;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              freeze, err;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_result;
    logic              mem_ack = 1'b0;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .freeze(freeze), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data(mem_data), .mem_result(mem_result), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          wr;
        int          word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          fcyc;
        int          rcyc;
        int          wcyc;
        logic [31:0] memval;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[MEM_WORDS];
    logic [31:0] tb_mem[MEM_WORDS];
    bit          ref_err   = 1'b0;
    logic [31:0] ref_rdata = '0;
    int          checks    = 0;
    int          errors    = 0;
    int          plan_wait = 1000;
    bit          force_ack = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h12345678;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Memory device: combinational read port, write committed on an acked edge.
    assign mem_result = tb_mem[mem_address];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (!rst && mem_write && mem_ack) tb_mem[mem_address] = mem_data;
        end
    end

    // Ack responder: acks after plan_wait strobe cycles; random noise when idle.
    initial begin
        int scnt;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                mem_ack = (scnt == plan_wait);
                scnt++;
            end else begin
                scnt = 0;
                mem_ack = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: an access completes where freeze falls; score it against the queue.
    initial begin
        int   fcnt, rcnt, wcnt, ovl;
        bit   prev_f;
        exp_t e;
        fcnt = 0; rcnt = 0; wcnt = 0; ovl = 0; prev_f = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fcnt = 0; rcnt = 0; wcnt = 0; ovl = 0; prev_f = 1'b0;
            end else begin
                if (mem_read && mem_write) ovl++;
                if (freeze) fcnt++;
                if (mem_read) rcnt++;
                if (mem_write) wcnt++;
                if (prev_f && !freeze) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("freeze_cycles", 32'(fcnt), 32'(e.fcyc));
                        chk("mem_read_cycles", 32'(rcnt), 32'(e.rcyc));
                        chk("mem_write_cycles", 32'(wcnt), 32'(e.wcyc));
                        chk("strobe_overlap", 32'(ovl), 32'd0);
                        chk("cpu_rdata", cpu_rdata, e.rdata);
                        chk("err", 32'(err), 32'(e.err));
                        if (e.valid) begin
                            chk("mem_address", 32'(mem_address), 32'(e.word));
                            chk("mem_word", tb_mem[e.word], e.memval);
                            if (e.wr) chk("mem_data", mem_data, e.wdata);
                        end
                    end
                    fcnt = 0; rcnt = 0; wcnt = 0; ovl = 0;
                end
                prev_f = freeze;
            end
        end
    end

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Issue one request, predict its outcome from the access rules, wait for DONE.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits, input bit gap);
        exp_t e;
        int   strobe;
        int   n;
        bit   acked;
        e.valid = (rd != wr) && (addr % 4 == 0) && (addr < 32'(4 * MEM_WORDS));
        e.wr    = wr;
        e.wdata = wd;
        e.word  = int'(addr / 4) % MEM_WORDS;
        e.rcyc  = 0;
        e.wcyc  = 0;
        if (!e.valid) begin
            e.fcyc    = 1;
            ref_err   = 1'b1;
            ref_rdata = '0;
        end else begin
            acked  = waits < TIMEOUT;
            strobe = acked ? waits + 1 : TIMEOUT;
            e.fcyc = strobe + 1;
            if (rd) e.rcyc = strobe; else e.wcyc = strobe;
            if (!acked) ref_err = 1'b1;
            if (rd) ref_rdata = acked ? ref_mem[e.word] : 32'd0;
            if (wr && acked) ref_mem[e.word] = wd;
        end
        e.memval = ref_mem[e.word];
        e.rdata  = ref_rdata;
        e.err    = ref_err;
        exp_q.push_back(e);
        plan_wait = waits;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (freeze && n < 60);
        if (freeze) begin
            errors++; checks++;
            $display("FAIL access_timeout: freeze still 1 after %0d cycles, expected DONE", n);
            finish_now();
        end
        @(posedge clk);
        #1;
        if (gap) begin
            cpu_rd = 1'b0; cpu_wr = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
    endtask

    // Abandon a read on its second cycle with an asynchronous reset.
    task automatic reset_mid_read();
        plan_wait = 1000;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h8; cpu_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1; cpu_rd = 1'b0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; force_ack = 1'b1;
        ref_err = 1'b0; ref_rdata = '0;
        @(posedge clk);
        #1;
        chk("late_ack_mem_read", 32'(mem_read), 32'd0);
        chk("late_ack_freeze", 32'(freeze), 32'd0);
        chk("late_ack_err", 32'(err), 32'd0);
        chk("late_ack_rdata", cpu_rdata, 32'd0);
        chk("late_ack_address", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("late_ack_idle", 32'({mem_read, mem_write, freeze}), 32'd0);
    endtask

    initial begin
        bit          rd, wr, gap;
        int          sel, w;
        logic [31:0] a;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk("reset_mem_address", 32'(mem_address), 32'd0);
        chk("reset_mem_data", mem_data, 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_freeze", 32'(freeze), 32'd0);
        rst = 1'b0;

        issue(1'b1, 1'b0, 32'h14, 32'h0, 0, 1'b0);
        issue(1'b0, 1'b1, 32'hFC, 32'hA5A5A5A5, 3, 1'b1);
        issue(1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b0);
        issue(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 0, 1'b0);
        issue(1'b1, 1'b0, 32'h8, 32'h0, 1, 1'b1);
        reset_mid_read();

        issue(1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b1);
        issue(1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        issue(1'b1, 1'b1, 32'h8, 32'h0, 0, 1'b1);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1000, 1'b1);
        issue(1'b1, 1'b0, 32'h24, 32'h0, TIMEOUT - 1, 1'b1);
        issue(1'b0, 1'b1, 32'h28, 32'h11223344, 1000, 1'b1);

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 19);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            a   = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            w   = $urandom_range(0, 4);
            gap = ($urandom_range(0, 2) == 0);
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = a | (32'd1 << $urandom_range(ADDR_W + 2, 31));
            else if (sel == 2) begin rd = 1'b1; wr = 1'b1; end
            if ($urandom_range(0, 9) == 0) w = TIMEOUT - 1 + $urandom_range(0, 1);
            issue(rd, wr, a, $urandom, w, gap);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        finish_now();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
